// File: rtl/l2_cache_write.sv
// rtl/l2_cache_write.sv - L2 write stage: store merge, SRAM update, response register, writeback FIFO
// Optional perf counters (pc_writebacks, pc_store_merges) enabled by L2_WRITE_PERF_COUNTERS_EN
package l2_cache_write_pkg;
  localparam int CACHE_LINE_BITS     = 512;
  localparam int CACHE_LINE_BYTES    = CACHE_LINE_BITS / 8;
  localparam int L2_SET_BITS         = 6;
  localparam int L2_WAY_BITS         = 2;
  localparam int L2_CACHE_ADDR_WIDTH = L2_WAY_BITS + L2_SET_BITS;
  localparam int L2_LINE_ADDR_BITS   = 26;
  localparam int L2_TAG_WIDTH        = L2_LINE_ADDR_BITS - L2_SET_BITS;

  typedef enum logic [2:0] {
    OP_LOAD, OP_STORE, OP_FLUSH, OP_LOAD_SYNC, OP_STORE_SYNC
  } l2_op_t;

  typedef struct packed {
    logic                        valid;
    l2_op_t                      op;
    logic [1:0]                  core;
    logic [1:0]                  strand;
    logic [25:0]                 address;
    logic [CACHE_LINE_BITS-1:0]  data;
    logic [CACHE_LINE_BYTES-1:0] mask;
  } l2req_packet_t;
endpackage

module l2_cache_write
  import l2_cache_write_pkg::*;
#(
  parameter int WB_FIFO_DEPTH   = 8,
  parameter int WB_STALL_MARGIN = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  l2req_packet_t                  rd_l2req_packet,
  input  logic                           rd_is_l2_fill,
  input  logic [CACHE_LINE_BITS-1:0]     rd_data_from_memory,
  input  logic                           rd_cache_hit,
  input  logic [CACHE_LINE_BITS-1:0]     rd_cache_mem_result,
  input  logic [L2_CACHE_ADDR_WIDTH-1:0] rd_cache_index,
  input  logic [L2_TAG_WIDTH-1:0]        rd_old_l2_tag,
  input  logic                           rd_line_is_dirty,
  input  logic                           rd_store_sync_success,
  output logic                           wr_update_enable,
  output logic [L2_CACHE_ADDR_WIDTH-1:0] wr_cache_write_index,
  output logic [CACHE_LINE_BITS-1:0]     wr_update_data,
  output l2req_packet_t                  wr_l2req_packet,
  output logic [CACHE_LINE_BITS-1:0]     wr_data,
  output logic                           wr_store_sync_success,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [25:0]                    wb_address,
  output logic [CACHE_LINE_BITS-1:0]     wb_data,
`ifdef L2_WRITE_PERF_COUNTERS_EN
  output logic [31:0]                    pc_writebacks,
  output logic [31:0]                    pc_store_merges,
`endif
  output logic                           wb_almost_full
);
  localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WB_FIFO_DEPTH);
  localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(WB_FIFO_DEPTH - WB_STALL_MARGIN);

  logic                           wr_update_enable_q, wr_update_enable_d;
  logic [L2_CACHE_ADDR_WIDTH-1:0] wr_cache_write_index_q, wr_cache_write_index_d;
  logic [CACHE_LINE_BITS-1:0]     wr_data_q, wr_data_d;
  l2req_packet_t                  wr_l2req_packet_q, wr_l2req_packet_d;
  logic                           wr_store_sync_success_q, wr_store_sync_success_d;

  logic [PTR_W-1:0] wb_wr_ptr_q, wb_wr_ptr_d, wb_rd_ptr_q, wb_rd_ptr_d;
  logic [PTR_W:0]   wb_count_q, wb_count_d;
  logic [25:0]                wb_addr_mem [WB_FIFO_DEPTH];
  logic [CACHE_LINE_BITS-1:0] wb_data_mem [WB_FIFO_DEPTH];

  logic                       act, merging, fwd_hit;
  logic [CACHE_LINE_BITS-1:0] base, merged;
  logic                       wb_push, wb_pop, wb_full, wb_push_ok;
  logic [25:0]                wb_push_addr;
  logic [CACHE_LINE_BITS-1:0] wb_push_data;

  // The write port registers double as the forward register: the line being written
  // this cycle is not yet visible in the SRAM read data for the request behind it.
  always_comb begin
    act     = rd_l2req_packet.valid && (rd_cache_hit || rd_is_l2_fill);
    merging = rd_l2req_packet.valid &&
              (rd_l2req_packet.op == OP_STORE ||
               (rd_l2req_packet.op == OP_STORE_SYNC && rd_store_sync_success));
    fwd_hit = wr_update_enable_q && (wr_cache_write_index_q == rd_cache_index) && !rd_is_l2_fill;
    base    = rd_is_l2_fill ? rd_data_from_memory : rd_cache_mem_result;
    if (fwd_hit) base = wr_data_q;
    merged = base;
    for (int i = 0; i < CACHE_LINE_BYTES; i++) begin
      if (merging && rd_l2req_packet.mask[i]) merged[8*i +: 8] = rd_l2req_packet.data[8*i +: 8];
    end

    wr_update_enable_d      = act && (rd_is_l2_fill || merging);
    wr_cache_write_index_d  = rd_cache_index;
    wr_data_d               = merged;
    wr_l2req_packet_d       = rd_l2req_packet;
    wr_store_sync_success_d = rd_store_sync_success;

    wb_push      = 1'b0;
    wb_push_addr = '0;
    wb_push_data = '0;
    if (rd_l2req_packet.valid && rd_is_l2_fill && rd_line_is_dirty) begin
      wb_push      = 1'b1;
      wb_push_addr = {rd_old_l2_tag, rd_cache_index[L2_SET_BITS-1:0]};
      wb_push_data = rd_cache_mem_result;
    end else if (rd_l2req_packet.valid && rd_l2req_packet.op == OP_FLUSH &&
                 rd_cache_hit && rd_line_is_dirty) begin
      wb_push      = 1'b1;
      wb_push_addr = rd_l2req_packet.address;
      wb_push_data = base;
    end

    wb_pop      = (wb_count_q != '0) && wb_ready;
    wb_full     = (wb_count_q == FULL_CNT);
    wb_push_ok  = wb_push && (!wb_full || wb_pop);
    wb_wr_ptr_d = wb_wr_ptr_q + PTR_W'(wb_push_ok);
    wb_rd_ptr_d = wb_rd_ptr_q + PTR_W'(wb_pop);
    wb_count_d  = wb_count_q + (PTR_W+1)'(wb_push_ok) - (PTR_W+1)'(wb_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_update_enable_q      <= 1'b0;
      wr_cache_write_index_q  <= '0;
      wr_data_q               <= '0;
      wr_l2req_packet_q       <= '0;
      wr_store_sync_success_q <= 1'b0;
      wb_wr_ptr_q             <= '0;
      wb_rd_ptr_q             <= '0;
      wb_count_q              <= '0;
    end else begin
      wr_update_enable_q      <= wr_update_enable_d;
      wr_cache_write_index_q  <= wr_cache_write_index_d;
      wr_data_q               <= wr_data_d;
      wr_l2req_packet_q       <= wr_l2req_packet_d;
      wr_store_sync_success_q <= wr_store_sync_success_d;
      wb_wr_ptr_q             <= wb_wr_ptr_d;
      wb_rd_ptr_q             <= wb_rd_ptr_d;
      wb_count_q              <= wb_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_push_ok) begin
      wb_addr_mem[wb_wr_ptr_q] <= wb_push_addr;
      wb_data_mem[wb_wr_ptr_q] <= wb_push_data;
    end
  end

  assign wr_update_enable      = wr_update_enable_q;
  assign wr_cache_write_index  = wr_cache_write_index_q;
  assign wr_update_data        = wr_data_q;
  assign wr_data               = wr_data_q;
  assign wr_l2req_packet       = wr_l2req_packet_q;
  assign wr_store_sync_success = wr_store_sync_success_q;
  assign wb_valid              = (wb_count_q != '0);
  assign wb_address            = wb_addr_mem[wb_rd_ptr_q];
  assign wb_data               = wb_data_mem[wb_rd_ptr_q];
  assign wb_almost_full        = (wb_count_q >= AF_CNT);

`ifdef L2_WRITE_PERF_COUNTERS_EN
  logic [31:0] pc_writebacks_q, pc_writebacks_d, pc_store_merges_q, pc_store_merges_d;

  always_comb begin
    pc_writebacks_d   = pc_writebacks_q + 32'(wb_push_ok);
    pc_store_merges_d = pc_store_merges_q + 32'(act && merging);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_writebacks_q   <= '0;
      pc_store_merges_q <= '0;
    end else begin
      pc_writebacks_q   <= pc_writebacks_d;
      pc_store_merges_q <= pc_store_merges_d;
    end
  end

  assign pc_writebacks   = pc_writebacks_q;
  assign pc_store_merges = pc_store_merges_q;
`endif

`ifndef SYNTHESIS
  wb_overflow: assert property (@(posedge clk) disable iff (reset) !(wb_push && wb_full && !wb_pop))
    else $error("writeback FIFO overflow: entry dropped");
`endif
endmodule

// File: tb/tb_l2_cache_write.sv
// tb/tb_l2_cache_write.sv - randomized bench for l2_cache_write against a behavioural model
module tb_l2_cache_write;
  import l2_cache_write_pkg::*;
  localparam int DEPTH = 8;
  localparam int AF    = 5;
  typedef logic [CACHE_LINE_BITS-1:0] line_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  l2req_packet_t pkt;
  logic fill, hit, dirty, ss, wb_ready;
  line_t mem_data, sram;
  logic [L2_CACHE_ADDR_WIDTH-1:0] idx;
  logic [L2_TAG_WIDTH-1:0] tag;

  logic upd_en, wr_ss, wb_valid, wb_af;
  logic [L2_CACHE_ADDR_WIDTH-1:0] upd_idx;
  line_t upd_data, wr_data, wb_data;
  l2req_packet_t wr_pkt;
  logic [25:0] wb_address;
`ifdef L2_WRITE_PERF_COUNTERS_EN
  logic [31:0] pc_writebacks, pc_store_merges;
`endif

  l2_cache_write dut (
    .clk(clk), .reset(reset),
    .rd_l2req_packet(pkt), .rd_is_l2_fill(fill), .rd_data_from_memory(mem_data),
    .rd_cache_hit(hit), .rd_cache_mem_result(sram), .rd_cache_index(idx),
    .rd_old_l2_tag(tag), .rd_line_is_dirty(dirty), .rd_store_sync_success(ss),
    .wr_update_enable(upd_en), .wr_cache_write_index(upd_idx), .wr_update_data(upd_data),
    .wr_l2req_packet(wr_pkt), .wr_data(wr_data), .wr_store_sync_success(wr_ss),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_address(wb_address), .wb_data(wb_data),
`ifdef L2_WRITE_PERF_COUNTERS_EN
    .pc_writebacks(pc_writebacks), .pc_store_merges(pc_store_merges),
`endif
    .wb_almost_full(wb_af)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          upd_en;
    logic [7:0]    upd_idx;
    line_t         upd_data;
    l2req_packet_t pkt;
    line_t         wdata;
    logic          ss;
  } exp_t;

  exp_t exp_cur, exp_next;
  logic [25:0] q_addr[$];
  line_t       q_data[$];
  bit          p_push, p_pop, p_sm;
  logic [25:0] p_addr;
  line_t       p_data;
  int unsigned pc_wb, pc_sm;
  bit          checking = 1'b0;

  function automatic void model_reset();
    exp_cur = '{1'b0, 8'h0, '0, '0, '0, 1'b0};
    exp_next = exp_cur;
    q_addr.delete();
    q_data.delete();
    p_push = 0; p_pop = 0; p_sm = 0; p_addr = '0; p_data = '0;
    pc_wb = 0; pc_sm = 0;
  endfunction

  // Outcome of the inputs currently applied, taking effect at the next clock edge.
  function automatic void model_compute();
    line_t base, merged;
    bit act, merging;
    act     = pkt.valid && (hit || fill);
    merging = pkt.valid && (pkt.op == OP_STORE || (pkt.op == OP_STORE_SYNC && ss));
    base    = fill ? mem_data : sram;
    if (!fill && exp_cur.upd_en && exp_cur.upd_idx == idx) base = exp_cur.upd_data;
    merged = base;
    for (int i = 0; i < CACHE_LINE_BYTES; i++)
      if (merging && pkt.mask[i]) merged[8*i +: 8] = pkt.data[8*i +: 8];
    exp_next.upd_en   = act && (fill || merging);
    exp_next.upd_idx  = idx;
    exp_next.upd_data = merged;
    exp_next.pkt      = pkt;
    exp_next.wdata    = merged;
    exp_next.ss       = ss;
    p_pop  = (q_addr.size() > 0) && wb_ready;
    p_push = 0;
    if (pkt.valid && fill && dirty) begin
      p_push = 1; p_addr = {tag, idx[5:0]}; p_data = sram;
    end else if (pkt.valid && pkt.op == OP_FLUSH && hit && dirty) begin
      p_push = 1; p_addr = pkt.address; p_data = base;
    end
    p_sm = act && merging;
  endfunction

  task automatic tick();
    @(posedge clk);
    exp_cur = exp_next;
    if (p_pop) begin void'(q_addr.pop_front()); void'(q_data.pop_front()); end
    if (p_push) begin q_addr.push_back(p_addr); q_data.push_back(p_data); pc_wb++; end
    if (p_sm) pc_sm++;
    p_push = 0; p_pop = 0; p_sm = 0;
    #1;
  endtask

  task automatic set_idle(input bit rdy);
    pkt = '0; fill = 0; hit = 0; dirty = 0; ss = 0; idx = '0; tag = '0;
    mem_data = '0; sram = '0; wb_ready = rdy;
  endtask

  task automatic drive(input l2_op_t op, input bit fl, input bit h, input bit d, input bit s,
                       input logic [7:0] ix, input logic [19:0] tg, input logic [63:0] mk,
                       input line_t dt, input line_t sr, input line_t md, input bit rdy);
    pkt = '0; pkt.valid = 1; pkt.op = op; pkt.address = 26'h12345; pkt.mask = mk; pkt.data = dt;
    fill = fl; hit = h; dirty = d; ss = s; idx = ix; tag = tg; sram = sr; mem_data = md;
    wb_ready = rdy;
    model_compute();
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < CACHE_LINE_BITS / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic rand_cycle();
    pkt         = '0;
    pkt.valid   = ($urandom_range(0, 9) != 0);
    pkt.op      = l2_op_t'(3'($urandom_range(0, 4)));
    pkt.core    = 2'($urandom);
    pkt.strand  = 2'($urandom);
    pkt.address = 26'($urandom);
    pkt.data    = rand_line();
    pkt.mask    = {$urandom, $urandom};
    fill        = ($urandom_range(0, 3) == 0);
    hit         = !fill && ($urandom_range(0, 3) != 0);
    dirty       = 1'($urandom);
    ss          = 1'($urandom);
    idx         = 8'($urandom_range(0, 3));
    tag         = 20'($urandom);
    mem_data    = rand_line();
    sram        = rand_line();
    wb_ready    = ($urandom_range(0, 2) != 0);
    if (q_addr.size() == DEPTH && !wb_ready) dirty = 0;
    model_compute();
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("upd_en", 640'(upd_en), 640'(exp_cur.upd_en));
      if (exp_cur.upd_en) begin
        chk("upd_idx", 640'(upd_idx), 640'(exp_cur.upd_idx));
        chk("upd_data", 640'(upd_data), 640'(exp_cur.upd_data));
      end
      chk("wr_pkt", 640'(wr_pkt), 640'(exp_cur.pkt));
      chk("wr_data", 640'(wr_data), 640'(exp_cur.wdata));
      chk("wr_ss", 640'(wr_ss), 640'(exp_cur.ss));
      chk("wb_valid", 640'(wb_valid), 640'(q_addr.size() > 0));
      if (q_addr.size() > 0) begin
        chk("wb_address", 640'(wb_address), 640'(q_addr[0]));
        chk("wb_data", 640'(wb_data), 640'(q_data[0]));
      end
      chk("wb_almost_full", 640'(wb_af), 640'(q_addr.size() >= AF));
`ifdef L2_WRITE_PERF_COUNTERS_EN
      chk("pc_writebacks", 640'(pc_writebacks), 640'(pc_wb));
      chk("pc_store_merges", 640'(pc_store_merges), 640'(pc_sm));
`endif
    end
  end

  initial begin
    line_t victim, filld;
    int guard;
    victim = {16{32'hDEADBEEF}};
    filld  = {16{32'h0F0F1234}};
    set_idle(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checking = 1;
    chk("reset_upd_en", 640'(upd_en), 640'(0));
    chk("reset_wb_valid", 640'(wb_valid), 640'(0));
    chk("reset_wr_data", 640'(wr_data), 640'(0));
    set_idle(0); model_compute(); tick();

    // single-byte store into an all-zero line
    drive(OP_STORE, 0, 1, 0, 0, 8'h10, 20'h0, 64'h1, line_t'(512'hAA), '0, '0, 0); tick();
    chk("store_b0_en", 640'(upd_en), 640'(1));
    chk("store_b0_data", 640'(upd_data), 640'(512'hAA));
    // back-to-back store to the same index sees the first store's byte
    drive(OP_STORE, 0, 1, 0, 0, 8'h10, 20'h0, 64'h2, line_t'(512'hBB00), '0, '0, 0); tick();
    chk("store_fwd_data", 640'(upd_data), 640'(512'hBBAA));
    // dirty fill: victim queued at {tag,set}, SRAM takes fill data
    drive(OP_LOAD, 1, 0, 1, 0, 8'h43, 20'd5, 64'h0, '0, victim, filld, 0); tick();
    chk("fill_wb_valid", 640'(wb_valid), 640'(1));
    chk("fill_wb_address", 640'(wb_address), 640'(26'h143));
    chk("fill_wb_data", 640'(wb_data), 640'(victim));
    chk("fill_upd_data", 640'(upd_data), 640'(filld));
    set_idle(1); model_compute(); tick();
    // failed sync store does not write
    drive(OP_STORE_SYNC, 0, 1, 0, 0, 8'h10, 20'h0, 64'hFF, rand_line(), '0, '0, 1); tick();
    chk("sync_fail_en", 640'(upd_en), 640'(0));
    chk("sync_fail_ss", 640'(wr_ss), 640'(0));

    // fill the writeback FIFO with wb_ready low
    for (int k = 1; k <= DEPTH; k++) begin
      drive(OP_LOAD, 1, 0, 1, 0, 8'(k), 20'(k), 64'h0, '0, rand_line(), rand_line(), 0); tick();
      if (k == 4) chk("af_after_4", 640'(wb_af), 640'(0));
      if (k == 5) chk("af_after_5", 640'(wb_af), 640'(1));
    end
    // push and pop while full: still full, head advances to the second entry
    drive(OP_LOAD, 1, 0, 1, 0, 8'h09, 20'h9, 64'h0, '0, rand_line(), rand_line(), 1); tick();
    chk("full_pushpop_head", 640'(wb_address), 640'(26'h82));
    chk("full_pushpop_size", 640'(q_addr.size()), 640'(DEPTH));

    repeat (800) begin rand_cycle(); tick(); end

    guard = 0;
    while (q_addr.size() > 0 && guard < 30) begin set_idle(1); model_compute(); tick(); guard++; end
    chk("drain_done", 640'(q_addr.size()), 640'(0));
    for (int k = 0; k < 3; k++) begin
      drive(OP_LOAD, 1, 0, 1, 0, 8'(k), 20'(k + 7), 64'h0, '0, rand_line(), rand_line(), 0); tick();
    end
    chk("pre_reset_queued", 640'(wb_valid), 640'(1));
    set_idle(0); model_compute();
    #2 reset = 1;
    model_reset();
    #1;
    chk("async_reset_wb_valid", 640'(wb_valid), 640'(0));
`ifdef L2_WRITE_PERF_COUNTERS_EN
    chk("async_reset_pc_wb", 640'(pc_writebacks), 640'(0));
    chk("async_reset_pc_sm", 640'(pc_store_merges), 640'(0));
`endif
    tick();
    reset = 0;
    set_idle(0); model_compute(); tick();
    repeat (100) begin rand_cycle(); tick(); end
    set_idle(1); model_compute(); tick();

    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
